// File: rtl/norm_seq_32b_pkg.sv
// norm_seq_32b_pkg: shared definitions for the sequential normalizer.
//   - FSM state encoding (IDLE / SCAN / DONE)
//   - direction constants (left = toward MSB, right = toward LSB)
//   - default operand and count widths
package norm_seq_32b_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 6;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/norm_seq_32b_step.sv
// norm_seq_32b_step: combinational single step of the normalizer (the norm_step stage).
//   word_i    : current shift-register contents
//   dir_i     : DIR_LEFT shifts toward MSB, DIR_RIGHT toward LSB
//   skip_en_i : allow a 4-bit step when the 4 bits nearest the target end are all zero
//   word_o    : shifted word (zero fill)
//   inc_o     : count increment for this step (1 or 4)
//   hit_o     : target-end bit of word_i is set (normalization complete)
module norm_seq_32b_step
    import norm_seq_32b_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic             dir_i,
    input  logic             skip_en_i,
    output logic [WIDTH-1:0] word_o,
    output logic [CNT_W-1:0] inc_o,
    output logic             hit_o
);

    logic nib_zero;

    always_comb begin
        hit_o    = (dir_i == DIR_RIGHT) ? word_i[0] : word_i[WIDTH-1];
        nib_zero = (dir_i == DIR_RIGHT) ? (word_i[3:0] == 4'h0)
                                        : (word_i[WIDTH-1 -: 4] == 4'h0);
        // A zero nibble at the target end means the first set bit lies beyond it,
        // so a 4-bit jump cannot overshoot.
        if (skip_en_i && nib_zero) begin
            word_o = (dir_i == DIR_RIGHT) ? (word_i >> 4) : (word_i << 4);
            inc_o  = CNT_W'(4);
        end else begin
            word_o = (dir_i == DIR_RIGHT) ? (word_i >> 1) : (word_i << 1);
            inc_o  = CNT_W'(1);
        end
    end

endmodule

// File: rtl/norm_seq_32b.sv
// norm_seq_32b: sequential normalizer (CLZ / CTZ helper).
// Shifts the operand toward the chosen end until its first set bit reaches that end,
// reporting the normalized word and the number of positions shifted.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only when busy=0 (accepted in IDLE and DONE)
//   dir        : 0 = normalize left (toward MSB), 1 = normalize right (toward LSB)
//   a          : operand
//   busy       : high while scanning
//   done       : one-cycle pulse when result/count/zero become valid
//   result     : normalized word
//   count      : positions shifted (WIDTH for a zero operand)
//   zero       : operand was all zeros
// Optional build macro NORM_NIBBLE_SKIP_EN: take 4-bit steps over zero nibbles.
module norm_seq_32b
    import norm_seq_32b_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

`ifdef NORM_NIBBLE_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] step_word;
    logic [CNT_W-1:0] step_inc;
    logic             step_hit;

    norm_seq_32b_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .word_i    (shreg_q),
        .dir_i     (dir_q),
        .skip_en_i (SKIP_EN),
        .word_o    (step_word),
        .inc_o     (step_inc),
        .hit_o     (step_hit)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        dir_d    = dir_q;
        result_d = result_q;
        count_d  = count_q;
        zero_d   = zero_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    shreg_d = a;
                    dir_d   = dir;
                    count_d = '0;
                    if (a == '0) begin
                        // Nothing to scan: report full width immediately.
                        zero_d   = 1'b1;
                        result_d = '0;
                        count_d  = CNT_W'(WIDTH);
                        state_d  = ST_DONE;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (step_hit) begin
                    result_d = shreg_q;
                    state_d  = ST_DONE;
                end else begin
                    shreg_d = step_word;
                    count_d = count_q + step_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            dir_q    <= DIR_LEFT;
            result_q <= '0;
            count_q  <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            count_q  <= count_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == ST_SCAN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign count  = count_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_norm_seq_32b.sv
// tb_norm_seq_32b: self-checking bench for norm_seq_32b.
// A behavioural model (leading/trailing zero count by plain search, latency by formula)
// predicts busy/done every cycle and the result fields whenever not busy; directed
// cases pin both model and DUT to hand-computed literals, then random traffic follows.
module tb_norm_seq_32b;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        dir;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [5:0]  count;
    logic        zero;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 0;

    norm_seq_32b dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .dir    (dir),
        .a      (a),
        .busy   (busy),
        .done   (done),
        .result (result),
        .count  (count),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic void ref_norm(input logic [31:0] v, input logic d,
                                     output logic [31:0] r, output int c);
        if (v == 32'h0) begin
            r = 32'h0;
            c = 32;
        end else begin
            c = 0;
            if (d == 1'b0) begin
                while (v[31-c] == 1'b0) c++;
                r = v << c;
            end else begin
                while (v[c] == 1'b0) c++;
                r = v >> c;
            end
        end
    endfunction

    function automatic int model_lat(input int k, input bit z);
        if (z) return 1;
`ifdef NORM_NIBBLE_SKIP_EN
        return k / 4 + k % 4 + 2;
`else
        return k + 2;
`endif
    endfunction

    function automatic int lat_sel(input int plain, input int nib);
`ifdef NORM_NIBBLE_SKIP_EN
        return nib;
`else
        return plain;
`endif
    endfunction

    logic        m_busy, m_done, m_zero;
    logic [31:0] m_res, p_res;
    int          m_cnt, p_cnt, m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_zero = 0; m_res = 0; m_cnt = 0; m_left = 0;
        end else if (!m_busy && start) begin
            ref_norm(a, dir, p_res, p_cnt);
            m_left = model_lat(p_cnt, (a == 32'h0)) - 1;
            m_zero = (a == 32'h0);
            if (m_left == 0) begin
                m_done = 1; m_busy = 0; m_res = p_res; m_cnt = p_cnt;
            end else begin
                m_done = 0; m_busy = 1;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_res = p_res; m_cnt = p_cnt;
            end
        end else begin
            m_done = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (!m_busy) begin
                chk("result", result, m_res);
                chk("count", count, m_cnt);
                chk("zero", zero, m_zero);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic go(input logic [31:0] va, input logic vd);
        start = 1'b1; a = va; dir = vd;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit seen = 0;
        lat = 1;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL timeout: done not seen within 100 cycles");
        end
    endtask

    task automatic check_lit(input string nm, input int lat, input int elat,
                             input logic [31:0] er, input int ec, input logic ez);
        chk({nm, ".lat"}, lat, elat);
        chk({nm, ".result"}, result, er);
        chk({nm, ".count"}, count, ec);
        chk({nm, ".zero"}, zero, ez);
        chk({nm, ".model_result"}, m_res, er);
        chk({nm, ".model_count"}, m_cnt, ec);
    endtask

    task automatic run_op(input string nm, input logic [31:0] va, input logic vd,
                          input logic [31:0] er, input int ec, input logic ez, input int elat);
        int lat;
        @(negedge clk);
        go(va, vd);
        wait_done(lat);
        check_lit(nm, lat, elat, er, ec, ez);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom % 4)
            0: v = $urandom;
            1: v = 32'h1 << ($urandom % 32);
            2: v = $urandom >> ($urandom % 32);
            default: v = ($urandom % 3 == 0) ? 32'h0 : ($urandom << ($urandom % 32));
        endcase
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int done_pulses;
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; a = 32'h0;
        repeat (2) @(negedge clk);
        check_en = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("left_1000", 32'h0000_1000, 1'b0, 32'h8000_0000, 19, 1'b0, lat_sel(21, 9));
        run_op("right_0a00", 32'h0000_0A00, 1'b1, 32'h0000_0005, 9, 1'b0, lat_sel(11, 5));
        run_op("zero_left", 32'h0, 1'b0, 32'h0, 32, 1'b1, 1);
        run_op("zero_right", 32'h0, 1'b1, 32'h0, 32, 1'b1, 1);
        run_op("norm_left", 32'h8000_0001, 1'b0, 32'h8000_0001, 0, 1'b0, 2);
        run_op("norm_right", 32'h8000_0001, 1'b1, 32'h8000_0001, 0, 1'b0, 2);
        run_op("one_left", 32'h0000_0001, 1'b0, 32'h8000_0000, 31, 1'b0, lat_sel(33, 12));

        // Start with a different operand mid-scan must be ignored.
        @(negedge clk);
        go(32'h0000_1000, 1'b0);
        repeat (3) @(negedge clk);
        go(32'hFFFF_FFFF, 1'b1);
        wait_done(lat);
        check_lit("ignore_mid", lat + 4, lat_sel(21, 9), 32'h8000_0000, 19, 1'b0);

        // Back-to-back: new start issued while in DONE.
        @(negedge clk);
        go(32'h0000_0A00, 1'b1);
        wait_done(lat);
        go(32'h0000_0100, 1'b0);
        wait_done(lat);
        check_lit("back2back", lat, lat_sel(25, 10), 32'h8000_0000, 23, 1'b0);

        // Asynchronous reset mid-scan: outputs clear at once, no done afterwards.
        @(negedge clk);
        go(32'h0000_0001, 1'b1 ^ 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.result", result, 32'h0);
        chk("rst.count", count, 6'd0);
        chk("rst.zero", zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_pulses++;
        end
        chk("rst.no_done", done_pulses, 0);

        // Random traffic, including starts while busy.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 4 == 0);
            dir   = $urandom % 2;
            a     = rand_operand();
            @(negedge clk);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/norm_seq_32b.md
Name: norm_seq_32b

Overview:
- Sequential normalizer: the inverse companion of the barrel shifter.
- Given an operand, it shifts the operand toward the chosen end until the first set bit reaches that end. It reports the normalized word and the shift amount: leading-zero count for left, trailing-zero count for right.
- The reported amount is the value that, fed back as a shift amount to the barrel shifter in the opposite direction, restores the original operand.
- Sits beside the ALU shift path; used by CLZ/CTZ-style instructions and multi-cycle datapath helpers.

Parameters:
- WIDTH, 32, operand width in bits.
- CNT_W, 6, width of the shift-count output; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- dir  input  1  0 = normalize left (toward MSB), 1 = normalize right (toward LSB); sampled with start.
- a  input  WIDTH  operand; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- result  output  WIDTH  normalized word.
- count  output  CNT_W  number of bit positions shifted.
- zero  output  1  operand was all zeros.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, result=0, count=0, zero=0.
- Reset mid-operation: the operation is abandoned immediately; no done pulse is produced after reset release.
- States: IDLE, SCAN, DONE.
- IDLE or DONE, start=1:
  - Load shift register <= a, dir_q <= dir, count <= 0.
  - If a==0: zero <= 1, result <= 0, count <= WIDTH, go to DONE.
  - Otherwise: zero <= 0, go to SCAN.
- IDLE or DONE, start=0: stay in IDLE. DONE always falls to IDLE after one cycle unless start=1.
- SCAN:
  - Target bit is reg[WIDTH-1] when dir_q=0, reg[0] when dir_q=1.
  - Target bit set: go to DONE; result <= reg.
  - Otherwise: shift reg one position toward the target end (zero fill), count <= count+1.
  - SCAN cannot run away, because the operand is nonzero; count never exceeds WIDTH-1 in SCAN.
- done: high exactly for the cycle spent in DONE.
- busy: high in SCAN only.
- start while busy=1: ignored; it is neither queued nor allowed to alter the operation in progress.
- start in DONE: accepted as a back-to-back operation, with no idle gap required.
- result, count and zero hold their values from DONE until the next accepted start.
- Latency, start edge to done high:
  - k+2 cycles for a nonzero operand with k = count.
  - 1 cycle for a zero operand.
- Arithmetic: count is an unsigned CNT_W-bit value; no wrap is possible.

Optional Feature:
- Macro NORM_NIBBLE_SKIP_EN.
- Defined: in SCAN, if the 4 bits nearest the target end are all zero, shift by 4 and add 4 to count in one cycle; otherwise fall back to the 1-bit step.
  - Latency becomes floor(k/4) + (k mod 4) + 2.
  - result and count are identical to the undefined build.
- Undefined: 1-bit step only.

Decomposition:
- Shared include/package contents:
  - State encodings: ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2.
  - Direction constants: DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - Default WIDTH/CNT_W values.
- Sub-module norm_step: combinational step that takes reg, dir and skip-enable, and returns the next reg, the count increment (1 or 4) and the target-bit-set flag.
- The FSM and registers stay in norm_seq_32b.

Test Plan:
- Left normalize: a=32'h0000_1000, dir=0, start pulse -> done 21 cycles after start, result=32'h8000_0000, count=19, zero=0. Busy is high for 20 cycles.
- Right normalize: a=32'h0000_0A00, dir=1 -> result=32'h0000_0005, count=9, done at cycle 11.
- Zero operand: a=0, either dir -> done 1 cycle after start, count=32, result=0, zero=1, busy never asserted.
- Already normalized: a=32'h8000_0001 -> dir=0 gives count=0, done at cycle 2; dir=1 gives count=0, done at cycle 2.
- Handshake hazards, each with the required response:
  - start with a different a, issued mid-SCAN: ignored; the results match the first operand.
  - start during DONE: accepted back-to-back, with a correct second result.
  - rst_n low mid-SCAN: all outputs are 0 asynchronously, and no done pulse follows.
- With NORM_NIBBLE_SKIP_EN: a=32'h0000_0001, dir=0 -> count=31, result=32'h8000_0000, done at cycle 12 (7+3+2). Without the macro, done is at cycle 33.
